unsat_clause_buffer: RTL and testbench

//  Upstream feeder of the WalkSAT clause register. Stores unsatisfied clause words
//  (3 x {neg_bit, 11-bit var index} = 36 bits) pushed by the clause checker.

---
 rtl/unsat_clause_buffer.sv | 147 ++++++++++++++
 tb/tb_unsat_clause_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/unsat_clause_buffer.sv
// unsat_clause_buffer
//   Upstream feeder of the WalkSAT clause register. Buffers unsatisfied clause
//   words from the clause checker in a circular array and presents the head
//   first-word-fall-through on the ucb_req/ucb_gnt handshake. Also raises
//   sat_flag once the buffer has stayed empty with no push for SAT_HOLD cycles.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   flush        discard contents, clear overflow/drop_cnt/sat detector
//   push_valid   push_clause is valid this cycle
//   push_clause  clause word {neg,var} x3, neg bits at [35]/[23]/[11]
//   ucb_req      [1] = buffer non-empty, [4:2] always 0
//   ucb_gnt      [1] = consumer takes the head this cycle, [4:2] ignored
//   reg_out      head entry while ucb_req[1]=1, else 0
//   occupancy    entries held, 0..DEPTH
//   full         occupancy == DEPTH
//   overflow     sticky: a push was dropped
//   drop_cnt     dropped pushes, saturating at 255
//   sat_flag     formula satisfied
module unsat_clause_buffer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned WIDTH    = 36,
    parameter int unsigned SAT_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_clause,
    output logic [4:1]       ucb_req,
    input  logic [4:1]       ucb_gnt,
    output logic [WIDTH-1:0] reg_out,
    output logic [AW:0]      occupancy,
    output logic             full,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic             sat_flag
);

    typedef enum logic [1:0] {
        S_BUSY = 2'd0,
        S_WAIT = 2'd1,
        S_SAT  = 2'd2
    } sat_state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             not_empty;
    logic             pop;
    logic             push_acc;
    logic             push_drop;
    logic             unused_gnt;

    sat_state_t       state, state_nxt;
    logic [7:0]       timer, timer_nxt;

    assign unused_gnt = ^ucb_gnt[4:2];

    assign not_empty = (occupancy != '0);
    assign full      = (occupancy == (AW+1)'(DEPTH));
    assign ucb_req   = {3'b000, not_empty};
    assign reg_out   = not_empty ? mem[rd_ptr] : '0;

    assign pop       = not_empty & ucb_gnt[1];
    // A pop frees a slot at the same edge, so a push into a full buffer is kept.
    assign push_acc  = push_valid & (~full | pop);
    assign push_drop = push_valid & full & ~pop;

    // Storage has no reset; only pointers and occupancy qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_acc)
            mem[wr_ptr] <= push_clause;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_acc && !pop)
                occupancy <= occupancy + 1'b1;
            else if (pop && !push_acc)
                occupancy <= occupancy - 1'b1;
            if (push_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= S_BUSY;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Timer >= compare (not ==) keeps SAT_HOLD=1 from wrapping the timer forever.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            S_BUSY: begin
                if (!not_empty && !push_valid) begin
                    state_nxt = S_WAIT;
                    timer_nxt = 8'd1;
                end
            end
            S_WAIT: begin
                if (push_valid || not_empty) begin
                    state_nxt = S_BUSY;
                    timer_nxt = '0;
                end else if (timer >= 8'(SAT_HOLD - 1)) begin
                    state_nxt = S_SAT;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            S_SAT: begin
                if (push_valid) begin
                    state_nxt = S_BUSY;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_BUSY;
                timer_nxt = '0;
            end
        endcase
    end

    assign sat_flag = (state == S_SAT);

endmodule

// File: tb/tb_unsat_clause_buffer.sv
module tb_unsat_clause_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned WIDTH = 36;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             push_valid;
    logic [WIDTH-1:0] push_clause;
    logic [4:1]       ucb_req;
    logic [4:1]       ucb_gnt;
    logic [WIDTH-1:0] reg_out;
    logic [AW:0]      occupancy;
    logic             full;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             sat_flag;

    int checks = 0;
    int errors = 0;

    unsat_clause_buffer #(
        .DEPTH(DEPTH),
        .AW(AW),
        .WIDTH(WIDTH),
        .SAT_HOLD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push_valid(push_valid),
        .push_clause(push_clause),
        .ucb_req(ucb_req),
        .ucb_gnt(ucb_gnt),
        .reg_out(reg_out),
        .occupancy(occupancy),
        .full(full),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word(input int unsigned i);
        return {4'h5, 32'h0100_0000 + 32'(i)};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},  64'(ucb_req),   64'h0);
        check({tag, "_out"},  64'(reg_out),   64'h0);
        check({tag, "_occ"},  64'(occupancy), 64'h0);
        check({tag, "_full"}, 64'(full),      64'h0);
        check({tag, "_ovf"},  64'(overflow),  64'h0);
        check({tag, "_drop"}, 64'(drop_cnt),  64'h0);
        check({tag, "_sat"},  64'(sat_flag),  64'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_clause = '0; ucb_gnt = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_values("reset");

        // 1: single push appears one cycle later
        push_valid = 1'b1; push_clause = 36'h8_0010_0203;
        tick();
        push_valid = 1'b0;
        check("t1_req", 64'(ucb_req),   64'h1);
        check("t1_out", 64'(reg_out),   64'h8_0010_0203);
        check("t1_occ", 64'(occupancy), 64'd1);
        ucb_gnt = 4'b0001;
        tick();
        ucb_gnt = '0;
        check("t1_empty", 64'(occupancy), 64'd0);

        // 2: fill, overflow by one, drain in order
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1; push_clause = word(i);
            tick();
        end
        check("t2_full", 64'(full),      64'h1);
        check("t2_occ",  64'(occupancy), 64'd16);
        push_clause = 36'hF_FFFF_FFFF;
        tick();
        push_valid = 1'b0;
        check("t2_ovf",     64'(overflow),  64'h1);
        check("t2_drop",    64'(drop_cnt),  64'd1);
        check("t2_occ_ovf", 64'(occupancy), 64'd16);
        ucb_gnt = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_drain%0d", i), 64'(reg_out), 64'(word(i)));
            tick();
        end
        ucb_gnt = '0;
        check("t2_req_end", 64'(ucb_req), 64'h0);
        check("t2_out_end", 64'(reg_out), 64'h0);

        // 3: push and pop together while full
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1; push_clause = word(100 + i);
            tick();
        end
        push_clause = 36'hA_BCDE_F012; ucb_gnt = 4'b0001;
        check("t3_head", 64'(reg_out), 64'(word(100)));
        tick();
        push_valid = 1'b0;
        check("t3_occ",  64'(occupancy), 64'd16);
        check("t3_drop", 64'(drop_cnt),  64'd1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t3_drain%0d", i), 64'(reg_out), 64'(word(100 + i)));
            tick();
        end
        check("t3_last", 64'(reg_out), 64'hA_BCDE_F012);
        tick();
        ucb_gnt = '0;
        check("t3_req_end", 64'(ucb_req), 64'h0);

        // 4: occupancy 1, push and pop together
        push_valid = 1'b1; push_clause = 36'h1_2345_6789;
        tick();
        push_clause = 36'h0_0BBB_0BBB; ucb_gnt = 4'b0001;
        check("t4_old_head", 64'(reg_out), 64'h1_2345_6789);
        tick();
        push_valid = 1'b0; ucb_gnt = '0;
        check("t4_new_head", 64'(reg_out),   64'h0_0BBB_0BBB);
        check("t4_occ",      64'(occupancy), 64'd1);
        ucb_gnt = 4'b0001;
        tick();
        ucb_gnt = '0;

        // 5: empty and idle; sat_flag rises 8 edges after the last pop edge
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("t5_nosat%0d", i), 64'(sat_flag), 64'h0);
        end
        tick();
        check("t5_sat", 64'(sat_flag), 64'h1);
        tick();
        check("t5_sat_hold", 64'(sat_flag), 64'h1);
        push_valid = 1'b1; push_clause = 36'h0_0000_0C0C;
        tick();
        check("t5_sat_clr", 64'(sat_flag),  64'h0);
        check("t5_occ",     64'(occupancy), 64'd1);

        // 6: occupancy 5 with overflow set, then flush (push+grant in flush cycle discarded)
        for (int i = 0; i < 4; i++) begin
            push_clause = word(200 + i);
            tick();
        end
        push_valid = 1'b0;
        check("t6_occ5", 64'(occupancy), 64'd5);
        check("t6_ovf",  64'(overflow),  64'h1);
        flush = 1'b1; push_valid = 1'b1; push_clause = 36'h7_7777_7777; ucb_gnt = 4'b0001;
        check("t6_flush_head", 64'(reg_out), 64'h0_0000_0C0C);
        tick();
        flush = 1'b0; push_valid = 1'b0; ucb_gnt = '0;
        check_reset_values("t6_flush");

        // drop_cnt saturation, cleared by flush
        push_valid = 1'b1;
        for (int i = 0; i < 16 + 270; i++) begin
            push_clause = word(300 + i);
            tick();
        end
        push_valid = 1'b0;
        check("sat_drop", 64'(drop_cnt), 64'd255);
        check("sat_occ",  64'(occupancy), 64'd16);
        check("sat_head", 64'(reg_out), 64'(word(300)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_drop_clr", 64'(drop_cnt), 64'd0);

        // rst mid-drain with grant held through reset
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_clause = word(600 + i);
            tick();
        end
        push_valid = 1'b0; ucb_gnt = 4'b0001;
        tick();
        check("t6_mid_occ",  64'(occupancy), 64'd2);
        check("t6_mid_head", 64'(reg_out),   64'(word(601)));
        rst = 1'b1;
        tick();
        rst = 1'b0; ucb_gnt = '0;
        check_reset_values("t6_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
